// File: rtl/float_recode_pkg.sv
// Shared constants and width/bias helpers for the IEEE-to-recoded float converter.
package float_recode_pkg;

    localparam int CLASS_W  = 4;
    localparam int CLS_ZERO = 0;
    localparam int CLS_SUB  = 1;
    localparam int CLS_INF  = 2;
    localparam int CLS_NAN  = 3;

    // Recoded format is one bit wider than IEEE: the exponent grows by one bit.
    function automatic int recoded_width(input int exp_w, input int sig_w);
        return exp_w + sig_w + 1;
    endfunction

    function automatic int recode_bias(input int exp_w);
        return (1 << (exp_w - 1)) + 1;
    endfunction

    function automatic int lz_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/recoded_normalize.sv
// Leading-zero count of a fraction and the fraction shifted past its leading one.
module recoded_normalize
    import float_recode_pkg::*;
#(
    parameter  int WIDTH = 52,
    localparam int LZ_W  = lz_width(WIDTH)
) (
    input  logic [WIDTH-1:0] fract,
    output logic [LZ_W-1:0]  lz,
    output logic [WIDTH-1:0] norm
);

    // Ascending scan: the highest set bit is the last one to write lz.
    always_comb begin
        lz = LZ_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (fract[i]) begin
                lz = LZ_W'(WIDTH - 1 - i);
            end
        end
    end

    assign norm = (fract << lz) << 1;

endmodule

// File: rtl/float_to_recoded_pipe.sv
// Two-stage valid/ready pipeline converting IEEE binary floats to recoded form.
module float_to_recoded_pipe
    import float_recode_pkg::*;
#(
    parameter int EXP_W = 11,
    parameter int SIG_W = 53,
    parameter int TAG_W = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+SIG_W-1:0]   in_data,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+SIG_W:0]     out_data,
    output logic [CLASS_W-1:0]       out_class,
    output logic [TAG_W-1:0]         out_tag
);

    localparam int FRAC_W = SIG_W - 1;
    localparam int REXP_W = EXP_W + 1;
    localparam int OUT_W  = recoded_width(EXP_W, SIG_W);
    localparam int LZ_W   = lz_width(FRAC_W);
    localparam logic [REXP_W-1:0] BIAS    = REXP_W'(recode_bias(EXP_W));
    localparam logic [REXP_W-1:0] EXP_INF = REXP_W'(3) << (REXP_W - 2);
    localparam logic [REXP_W-1:0] EXP_NAN = EXP_INF | (REXP_W'(1) << (EXP_W - 2));

    logic                in_sign;
    logic [EXP_W-1:0]    in_exp;
    logic [FRAC_W-1:0]   in_fract;
    logic [CLASS_W-1:0]  in_class;
    logic [LZ_W-1:0]     in_lz;
    logic [FRAC_W-1:0]   in_norm;

    logic                s1_valid;
    logic                s2_valid;
    logic                advance_s2;
    logic                s1_sign;
    logic [EXP_W-1:0]    s1_exp;
    logic [FRAC_W-1:0]   s1_fract;
    logic [LZ_W-1:0]     s1_lz;
    logic [CLASS_W-1:0]  s1_class;
    logic [TAG_W-1:0]    s1_tag;

    logic [REXP_W-1:0]   rec_exp;
    logic [FRAC_W-1:0]   rec_fract;

    assign in_sign  = in_data[EXP_W+SIG_W-1];
    assign in_exp   = in_data[FRAC_W +: EXP_W];
    assign in_fract = in_data[FRAC_W-1:0];

    always_comb begin
        in_class           = '0;
        in_class[CLS_ZERO] = (in_exp == '0) && (in_fract == '0);
        in_class[CLS_SUB]  = (in_exp == '0) && (in_fract != '0);
        in_class[CLS_INF]  = (&in_exp) && (in_fract == '0);
        in_class[CLS_NAN]  = (&in_exp) && (in_fract != '0);
    end

    recoded_normalize #(
        .WIDTH (FRAC_W)
    ) u_normalize (
        .fract (in_fract),
        .lz    (in_lz),
        .norm  (in_norm)
    );

    // A stage may load whenever the stage after it is empty or draining this cycle.
    assign advance_s2 = ~s2_valid | out_ready;
    assign in_ready   = ~s1_valid | advance_s2;
    assign out_valid  = s2_valid;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (advance_s2) begin
                s2_valid <= s1_valid;
            end
        end
    end

    // Subnormal fractions are normalised before registering so S2 only selects.
    always_ff @(posedge clock) begin
        if (in_valid && in_ready) begin
            s1_sign  <= in_sign;
            s1_exp   <= in_exp;
            s1_fract <= in_class[CLS_SUB] ? in_norm : in_fract;
            s1_lz    <= in_lz;
            s1_class <= in_class;
            s1_tag   <= in_tag;
        end
    end

    always_comb begin
        rec_exp   = {1'b0, s1_exp} + BIAS;
        rec_fract = s1_fract;
        if (s1_class[CLS_ZERO]) begin
            rec_exp   = '0;
            rec_fract = '0;
        end else if (s1_class[CLS_SUB]) begin
            rec_exp = BIAS - REXP_W'(s1_lz);
        end else if (s1_class[CLS_INF]) begin
            rec_exp = EXP_INF;
        end else if (s1_class[CLS_NAN]) begin
            rec_exp = EXP_NAN;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_data  <= '0;
            out_class <= '0;
            out_tag   <= '0;
        end else if (advance_s2 && s1_valid) begin
            out_data  <= OUT_W'({s1_sign, rec_exp, rec_fract});
            out_class <= s1_class;
            out_tag   <= s1_tag;
        end
    end

endmodule

// File: tb/tb_float_to_recoded_pipe.sv
// Scoreboard bench for float_to_recoded_pipe at the default double-precision build.
module tb_float_to_recoded_pipe;

    localparam int EXP_W = 11;
    localparam int SIG_W = 53;
    localparam int TAG_W = 4;

    typedef struct {
        logic [64:0]      data;
        logic [3:0]       cls;
        logic [TAG_W-1:0] tag;
        int               cycle;
    } exp_t;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              in_valid;
    logic              in_ready;
    logic [63:0]       in_data;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [64:0]       out_data;
    logic [3:0]        out_class;
    logic [TAG_W-1:0]  out_tag;

    exp_t              sb[$];
    exp_t              pending;
    int                num_checks = 0;
    int                num_errors = 0;
    int                cycle_count = 0;
    int                burst_start = 0;
    bit                check_latency = 1'b0;
    bit                saw_in_stall = 1'b0;
    bit                accepted = 1'b0;
    logic [TAG_W-1:0]  tag_ctr = '0;

    float_to_recoded_pipe #(
        .EXP_W (EXP_W),
        .SIG_W (SIG_W),
        .TAG_W (TAG_W)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_class (out_class),
        .out_tag   (out_tag)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference: subnormals are renormalised by shifting until the hidden bit appears.
    function automatic void refModel(input logic [63:0] x, output logic [64:0] d, output logic [3:0] c);
        logic        s;
        logic [10:0] e;
        logic [51:0] f;
        logic [52:0] m;
        int          shifts;
        s = x[63];
        e = x[62:52];
        f = x[51:0];
        if (e == 11'h7FF) begin
            d = {s, (f == '0) ? 12'hC00 : 12'hE00, f};
            c = (f == '0) ? 4'b0100 : 4'b1000;
        end else if (e == '0 && f == '0) begin
            d = {s, 64'd0};
            c = 4'b0001;
        end else if (e == '0) begin
            m = {1'b0, f};
            shifts = 0;
            while (!m[52] && shifts < 60) begin
                m = m << 1;
                shifts++;
            end
            d = {s, 12'(1026 - shifts), m[51:0]};
            c = 4'b0010;
        end else begin
            d = {s, 12'({1'b0, e} + 12'd1025), f};
            c = 4'b0000;
        end
    endfunction

    function automatic logic [63:0] randOperand();
        logic [63:0] x;
        x = {$urandom(), $urandom()};
        case ($urandom_range(0, 9))
            0: x[62:0] = '0;
            1, 2: begin
                x[62:52] = '0;
                x[51:0] = x[51:0] >> $urandom_range(0, 51);
                if (x[51:0] == '0) x[0] = 1'b1;
            end
            3: begin
                x[62:52] = '1;
                x[51:0] = '0;
            end
            4: begin
                x[62:52] = '1;
                if (x[51:0] == '0) x[0] = 1'b1;
            end
            default: begin
                if (x[62:52] == '0 || x[62:52] == 11'h7FF) x[62:52] = 11'h400;
            end
        endcase
        return x;
    endfunction

    // Called at a falling edge with inputs already driven; records the transfers the next rising edge performs.
    task automatic tick();
        exp_t e;
        #1;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checkOutput("spurious_out", 128'(out_valid), 128'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("out_data", 128'(out_data), 128'(e.data));
                checkOutput("out_class", 128'(out_class), 128'(e.cls));
                checkOutput("out_tag", 128'(out_tag), 128'(e.tag));
                if (check_latency) checkOutput("latency", 128'(cycle_count - e.cycle), 128'd2);
            end
        end
        accepted = in_valid && in_ready;
        if (accepted) begin
            e = pending;
            e.cycle = cycle_count;
            sb.push_back(e);
        end
        if (in_valid && !in_ready) saw_in_stall = 1'b1;
        @(negedge clock);
        cycle_count++;
    endtask

    // mode: 0 ready high, 1 random stalls, 2 stall window cycles 3-6 of a burst, 3 ready low.
    task automatic applyStimulus(input logic [63:0] data, input logic [64:0] exp_data,
                                 input logic [3:0] exp_cls, input int mode);
        int guard;
        guard = 0;
        in_valid = 1'b1;
        in_data = data;
        in_tag = tag_ctr;
        pending.data = exp_data;
        pending.cls = exp_cls;
        pending.tag = tag_ctr;
        do begin
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 3) != 0);
                2: out_ready = !((cycle_count - burst_start) >= 3 && (cycle_count - burst_start) <= 6);
                default: out_ready = 1'b0;
            endcase
            tick();
            guard++;
        end while (!accepted && guard < 50);
        if (!accepted) checkOutput("accept_timeout", 128'd0, 128'd1);
        in_valid = 1'b0;
        tag_ctr++;
    endtask

    task automatic applyModelled(input logic [63:0] data, input int mode);
        logic [64:0] d;
        logic [3:0]  c;
        refModel(data, d, c);
        applyStimulus(data, d, c, mode);
    endtask

    task automatic drain(input int cycles);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (cycles) tick();
        checkOutput("drain_empty", 128'(sb.size()), 128'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_tag = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        checkOutput("reset_in_ready", 128'(in_ready), 128'd1);
        checkOutput("reset_out_valid", 128'(out_valid), 128'd0);
        checkOutput("reset_out_data", 128'(out_data), 128'd0);
        checkOutput("reset_out_class", 128'(out_class), 128'd0);
        checkOutput("reset_out_tag", 128'(out_tag), 128'd0);
        @(negedge clock);
        reset_n = 1'b1;

        check_latency = 1'b1;
        applyStimulus(64'h3FF0000000000000, 65'h0_8000_0000_0000_0000, 4'b0000, 0);
        drain(4);
        applyStimulus(64'h0000000000000001, 65'h0_3CE0_0000_0000_0000, 4'b0010, 0);
        drain(4);
        applyStimulus(64'h8000000000000000, 65'h1_0000_0000_0000_0000, 4'b0001, 0);
        drain(4);
        applyStimulus(64'h7FF0000000000000, 65'h0_C000_0000_0000_0000, 4'b0100, 0);
        drain(4);
        applyStimulus(64'h7FF8000000000000, 65'h0_E008_0000_0000_0000, 4'b1000, 0);
        drain(4);
        applyStimulus(64'hBFF8000000000000, 65'h1_8008_0000_0000_0000, 4'b0000, 0);
        applyStimulus(64'h000FFFFFFFFFFFFF, 65'h0_401F_FFFF_FFFF_FFFE, 4'b0010, 0);
        applyStimulus(64'h7FEFFFFFFFFFFFFF, 65'h0_BFFF_FFFF_FFFF_FFFF, 4'b0000, 0);
        applyStimulus(64'h0010000000000000, 65'h0_4020_0000_0000_0000, 4'b0000, 0);
        drain(4);
        check_latency = 1'b0;

        burst_start = cycle_count;
        saw_in_stall = 1'b0;
        for (int i = 0; i < 10; i++) applyModelled(randOperand(), 2);
        drain(6);
        checkOutput("burst_in_ready_low", 128'(saw_in_stall), 128'd1);

        applyModelled(randOperand(), 3);
        applyModelled(randOperand(), 3);
        #1;
        checkOutput("full_in_ready", 128'(in_ready), 128'd0);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("async_out_valid", 128'(out_valid), 128'd0);
        checkOutput("async_in_ready", 128'(in_ready), 128'd1);
        checkOutput("async_out_data", 128'(out_data), 128'd0);
        checkOutput("async_out_tag", 128'(out_tag), 128'd0);
        sb.delete();
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        drain(6);
        check_latency = 1'b1;
        applyStimulus(64'h3FF0000000000000, 65'h0_8000_0000_0000_0000, 4'b0000, 0);
        drain(4);
        check_latency = 1'b0;

        for (int i = 0; i < 2000; i++) applyModelled(randOperand(), 1);
        drain(8);

        $display("== %0d vectors applied, %0d miscompares ==", num_checks, num_errors);
        $finish;
    end

endmodule
